// File: rtl/k16_io_input_filter.sv
// Debounce and edge-capture filter for the two 16-bit K16 scanner input words, with a small
// CPU register port and level interrupt. Optional build macro: K16_IO_FALL_EDGE_EN.
module k16_io_input_filter #(
  parameter int unsigned SAMPLE_DIV = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  select,
  input  logic [15:0] cpuInput0,
  input  logic [15:0] cpuInput1,
  input  logic [2:0]  addr,
  input  logic        wr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        irq
);

  localparam logic [15:0] CntMax = 16'(SAMPLE_DIV - 1);

  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        frame_tick, sample_tick;

  logic [31:0] raw, agree;
  logic [31:0] h0_q, h0_d, h1_q, h1_d;
  logic [31:0] stable_q, stable_d;
  logic [31:0] edge_set, pend_clr;
  logic [31:0] pend_q, pend_d;
  logic [31:0] mask_q, mask_d;
  logic [15:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;

  assign frame_tick  = (select == 3'd0);
  assign sample_tick = frame_tick && (frame_cnt_q == CntMax);

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_tick) begin
      frame_cnt_d = sample_tick ? 16'd0 : frame_cnt_q + 16'd1;
    end
  end

  assign raw = {cpuInput1, cpuInput0};

  // A bit is accepted only when the new sample matches both history samples.
  assign agree = ~(raw ^ h0_q) & ~(raw ^ h1_q);

  always_comb begin
    stable_d = stable_q;
    h0_d     = h0_q;
    h1_d     = h1_q;
    if (sample_tick) begin
      stable_d = (agree & raw) | (~agree & stable_q);
      h1_d     = h0_q;
      h0_d     = raw;
    end
  end

`ifdef K16_IO_FALL_EDGE_EN
  assign edge_set = stable_d ^ stable_q;
`else
  assign edge_set = stable_d & ~stable_q;
`endif

  always_comb begin
    pend_clr = '0;
    mask_d   = mask_q;
    if (wr) begin
      case (addr)
        3'd2:    pend_clr[15:0]  = wdata;
        3'd3:    pend_clr[31:16] = wdata;
        3'd4:    mask_d[15:0]    = wdata;
        3'd5:    mask_d[31:16]   = wdata;
        default: ;
      endcase
    end
  end

  // Set has priority over a same-cycle write-1-to-clear.
  assign pend_d = (pend_q & ~pend_clr) | edge_set;

  // Reads sample pre-write, pre-update state.
  always_comb begin
    case (addr)
      3'd0:    rdata_d = stable_q[15:0];
      3'd1:    rdata_d = stable_q[31:16];
      3'd2:    rdata_d = pend_q[15:0];
      3'd3:    rdata_d = pend_q[31:16];
      3'd4:    rdata_d = mask_q[15:0];
      3'd5:    rdata_d = mask_q[31:16];
      default: rdata_d = 16'd0;
    endcase
  end

  assign irq_d = |(pend_q & mask_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      h0_q        <= '0;
      h1_q        <= '0;
      stable_q    <= '0;
      pend_q      <= '0;
      mask_q      <= '0;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      h0_q        <= h0_d;
      h1_q        <= h1_d;
      stable_q    <= stable_d;
      pend_q      <= pend_d;
      mask_q      <= mask_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule
